// File: rtl/alu_pkg.sv
// Shared opcodes, flag bit positions, FSM encoding and response payload for alu_seq.
package alu_pkg;

    localparam int unsigned ALU_W  = 8;
    localparam int unsigned OP_W   = 8;
    localparam int unsigned FLAG_W = 7;

    localparam logic [OP_W-1:0] OP_ADD  = 8'h01;
    localparam logic [OP_W-1:0] OP_SUB  = 8'h02;
    localparam logic [OP_W-1:0] OP_MUL  = 8'h03;
    localparam logic [OP_W-1:0] OP_DIV  = 8'h04;
    localparam logic [OP_W-1:0] OP_INC  = 8'h05;
    localparam logic [OP_W-1:0] OP_DEC  = 8'h06;
    localparam logic [OP_W-1:0] OP_MOD  = 8'h07;
    localparam logic [OP_W-1:0] OP_SHL  = 8'h08;
    localparam logic [OP_W-1:0] OP_SHR  = 8'h09;
    localparam logic [OP_W-1:0] OP_AND  = 8'h0A;
    localparam logic [OP_W-1:0] OP_NAND = 8'h0B;
    localparam logic [OP_W-1:0] OP_NOR  = 8'h0D;
    localparam logic [OP_W-1:0] OP_OR   = 8'h0F;
    localparam logic [OP_W-1:0] OP_XNOR = 8'h10;
    localparam logic [OP_W-1:0] OP_XOR  = 8'h11;

    localparam int unsigned F_CARRY = 0;
    localparam int unsigned F_ZERO  = 1;
    localparam int unsigned F_NEG   = 2;
    localparam int unsigned F_OVF   = 3;
    localparam int unsigned F_PAR   = 4;
    localparam int unsigned F_DZ    = 5;
    localparam int unsigned F_INV   = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_DONE = 2'd2
    } alu_state_e;

    typedef struct packed {
        logic [ALU_W-1:0]  result;
        logic [FLAG_W-1:0] flags;
    } alu_resp_t;

    // Zero, negative and even-parity always derive from the final result.
    function automatic logic [FLAG_W-1:0] make_flags(input logic [ALU_W-1:0] r,
                                                      input logic carry,
                                                      input logic ovf,
                                                      input logic dz,
                                                      input logic inv);
        logic [FLAG_W-1:0] f;
        f          = '0;
        f[F_CARRY] = carry;
        f[F_ZERO]  = (r == '0);
        f[F_NEG]   = r[ALU_W-1];
        f[F_OVF]   = ovf;
        f[F_PAR]   = ~^r;
        f[F_DZ]    = dz;
        f[F_INV]   = inv;
        return f;
    endfunction

endpackage

// File: rtl/alu_seq_iter.sv
// Shared shift-add multiply / restoring divide datapath; one step per cycle, ITER steps total.
// Only instantiated when ALU_SEQ_MULDIV_EN is defined.
module alu_seq_iter
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_W,
    parameter int unsigned ITER  = ALU_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               div_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic               done_o,
    output logic [2*WIDTH-1:0] acc_o
);

    localparam int unsigned CNT_W = $clog2(ITER + 1);

    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH-1:0]   op_q;
    logic               div_q;
    logic               run_q;
    logic               done_q;
    logic [CNT_W-1:0]   cnt_q;

    // acc holds {hi, lo}: product halves for MUL, {remainder, quotient} for DIV.
    function automatic logic [2*WIDTH-1:0] step(input logic [2*WIDTH-1:0] acc,
                                                input logic [WIDTH-1:0]   dv,
                                                input logic               div);
        logic [WIDTH:0]   sum;
        logic [WIDTH:0]   trial;
        logic [WIDTH-1:0] rem;
        logic             ge;
        sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, dv} : '0);
        trial = acc[2*WIDTH-1:WIDTH-1];
        ge    = (trial >= {1'b0, dv});
        rem   = ge ? WIDTH'(trial - {1'b0, dv}) : trial[WIDTH-1:0];
        return div ? {rem, acc[WIDTH-2:0], ge} : {sum, acc[WIDTH-1:1]};
    endfunction

    // First step is taken on the start edge so the result is ready ITER-1 cycles later.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q  <= '0;
            op_q   <= '0;
            div_q  <= 1'b0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            done_q <= 1'b0;
            if (start_i) begin
                acc_q <= step({WIDTH'(0), a_i}, b_i, div_i);
                op_q  <= b_i;
                div_q <= div_i;
                run_q <= 1'b1;
                cnt_q <= CNT_W'(1);
            end else if (run_q) begin
                acc_q <= step(acc_q, op_q, div_q);
                cnt_q <= cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(ITER - 1)) begin
                    run_q  <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign done_o = done_q;
    assign acc_o  = acc_q;

endmodule

// File: rtl/alu_seq.sv
// Handshaked sequential ALU: single-cycle logic/arith ops, iterative MUL/DIV/MOD.
// Iterative ops are built only when ALU_SEQ_MULDIV_EN is defined; otherwise they decode as invalid.
module alu_seq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_W,
    parameter int unsigned ITER  = ALU_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [OP_W-1:0]   ALU_sel,
    input  logic [WIDTH-1:0]  operand1,
    input  logic [WIDTH-1:0]  operand2,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [WIDTH-1:0]  operation_result,
    output logic [FLAG_W-1:0] Flags
);

    localparam int unsigned MSB = WIDTH - 1;

    if (ITER != WIDTH || WIDTH != ALU_W) begin : g_bad_cfg
        $error("alu_seq: WIDTH and ITER must both be 8");
    end

    alu_state_e     state_q;
    logic           req_ready_q;
    logic           resp_valid_q;
    alu_resp_t      resp_q;

    logic [WIDTH:0]   sum_c;
    logic [WIDTH-1:0] res_c;
    logic             carry_c;
    logic             ovf_c;
    logic             inv_c;
    logic             iter_op_c;
    logic             accept_c;

    assign sum_c    = {1'b0, operand1} + {1'b0, operand2};
    assign accept_c = req_valid && req_ready_q;

    // Single-cycle result and carry/overflow, evaluated on the live request inputs.
    always_comb begin
        res_c   = '0;
        carry_c = 1'b0;
        ovf_c   = 1'b0;
        inv_c   = 1'b0;
        case (ALU_sel)
            OP_ADD: begin
                res_c   = sum_c[WIDTH-1:0];
                carry_c = sum_c[WIDTH];
                ovf_c   = ~(operand1[MSB] ^ operand2[MSB]) & (res_c[MSB] ^ operand1[MSB]);
            end
            OP_SUB: begin
                res_c   = operand1 - operand2;
                carry_c = (operand1 < operand2);
                ovf_c   = (operand1[MSB] ^ operand2[MSB]) & (res_c[MSB] ^ operand1[MSB]);
            end
            OP_INC: begin
                res_c   = operand1 + WIDTH'(1);
                carry_c = &operand1;
                ovf_c   = ~operand1[MSB] & res_c[MSB];
            end
            OP_DEC: begin
                res_c   = operand1 - WIDTH'(1);
                carry_c = (operand1 == '0);
                ovf_c   = operand1[MSB] & ~res_c[MSB];
            end
            OP_SHL: begin
                res_c   = {operand1[WIDTH-2:0], 1'b0};
                carry_c = operand1[MSB];
            end
            OP_SHR: begin
                res_c   = {1'b0, operand1[WIDTH-1:1]};
                carry_c = operand1[0];
            end
            OP_AND:  res_c = operand1 & operand2;
            OP_NAND: res_c = ~(operand1 & operand2);
            OP_NOR:  res_c = ~(operand1 | operand2);
            OP_OR:   res_c = operand1 | operand2;
            OP_XNOR: res_c = ~(operand1 ^ operand2);
            OP_XOR:  res_c = operand1 ^ operand2;
            default: inv_c = 1'b1;
        endcase
    end

`ifdef ALU_SEQ_MULDIV_EN
    logic [OP_W-1:0]    kind_q;
    logic               dz_q;
    logic               it_done;
    logic [2*WIDTH-1:0] it_acc;
    logic [WIDTH-1:0]   it_res_c;
    logic               it_carry_c;
    logic               it_dz_c;

    assign iter_op_c = (ALU_sel == OP_MUL) || (ALU_sel == OP_DIV) || (ALU_sel == OP_MOD);

    alu_seq_iter #(
        .WIDTH (WIDTH),
        .ITER  (ITER)
    ) u_iter (
        .clk     (clk),
        .rst     (rst),
        .start_i (accept_c && iter_op_c),
        .div_i   (ALU_sel != OP_MUL),
        .a_i     (operand1),
        .b_i     (operand2),
        .done_o  (it_done),
        .acc_o   (it_acc)
    );

    // Divide-by-zero falls out of restoring division: quotient all ones, remainder = dividend.
    always_comb begin
        it_res_c   = '0;
        it_carry_c = 1'b0;
        it_dz_c    = 1'b0;
        case (kind_q)
            OP_MUL: begin
                it_res_c   = it_acc[WIDTH-1:0];
                it_carry_c = |it_acc[2*WIDTH-1:WIDTH];
            end
            OP_DIV: begin
                it_res_c = it_acc[WIDTH-1:0];
                it_dz_c  = dz_q;
            end
            default: begin
                it_res_c = it_acc[2*WIDTH-1:WIDTH];
                it_dz_c  = dz_q;
            end
        endcase
    end
`else
    assign iter_op_c = 1'b0;
`endif

    // Control FSM; all handshake and response outputs are registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_q       <= '0;
`ifdef ALU_SEQ_MULDIV_EN
            kind_q       <= '0;
            dz_q         <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept_c) begin
                        req_ready_q <= 1'b0;
                        if (iter_op_c) begin
                            state_q <= ST_ITER;
`ifdef ALU_SEQ_MULDIV_EN
                            kind_q  <= ALU_sel;
                            dz_q    <= (operand2 == '0);
`endif
                        end else begin
                            state_q      <= ST_DONE;
                            resp_valid_q <= 1'b1;
                            resp_q       <= '{result: res_c,
                                              flags:  make_flags(res_c, carry_c, ovf_c, 1'b0, inv_c)};
                        end
                    end
                end
                ST_ITER: begin
`ifdef ALU_SEQ_MULDIV_EN
                    if (it_done) begin
                        state_q      <= ST_DONE;
                        resp_valid_q <= 1'b1;
                        resp_q       <= '{result: it_res_c,
                                          flags:  make_flags(it_res_c, it_carry_c, 1'b0, it_dz_c, 1'b0)};
                    end
`else
                    state_q     <= ST_IDLE;
                    req_ready_q <= 1'b1;
`endif
                end
                ST_DONE: begin
                    if (resp_ready) begin
                        state_q      <= ST_IDLE;
                        resp_valid_q <= 1'b0;
                        req_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    req_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready        = req_ready_q;
    assign resp_valid       = resp_valid_q;
    assign operation_result = resp_q.result;
    assign Flags            = resp_q.flags;

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq; expectations follow ALU_SEQ_MULDIV_EN.
module tb_alu_seq;

`ifdef ALU_SEQ_MULDIV_EN
    localparam bit MD = 1'b1;
`else
    localparam bit MD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic [7:0] ALU_sel;
    logic [7:0] operand1;
    logic [7:0] operand2;
    logic       resp_valid;
    logic       resp_ready;
    logic [7:0] operation_result;
    logic [6:0] Flags;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    alu_seq dut (
        .clk              (clk),
        .rst              (rst),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .ALU_sel          (ALU_sel),
        .operand1         (operand1),
        .operand2         (operand2),
        .resp_valid       (resp_valid),
        .resp_ready       (resp_ready),
        .operation_result (operation_result),
        .Flags            (Flags)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present one request for a single edge, then scramble inputs to prove they were captured.
    task automatic issue(input string tag, input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        check({tag, " ready"}, req_ready, 1);
        req_valid = 1'b1;
        ALU_sel   = op;
        operand1  = a;
        operand2  = b;
        @(negedge clk);
        req_valid = 1'b0;
        ALU_sel   = 8'h0E;
        operand1  = 8'($urandom);
        operand2  = 8'($urandom);
    endtask

    task automatic wait_resp(output int lat, output bit busy_ok);
        lat     = 1;
        busy_ok = 1'b1;
        while (resp_valid !== 1'b1 && lat < 40) begin
            if (req_ready !== 1'b0) busy_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        if (req_ready !== 1'b0) busy_ok = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [7:0] op, input logic [7:0] a,
                          input logic [7:0] b, input logic [7:0] exp_r, input logic [6:0] exp_f,
                          input int exp_lat);
        int lat;
        bit bok;
        issue(tag, op, a, b);
        wait_resp(lat, bok);
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " busy"}, bok, 1);
        check({tag, " result"}, operation_result, exp_r);
        check({tag, " flags"}, Flags, exp_f);
        @(negedge clk);
        check({tag, " taken"}, {resp_valid, req_ready}, 2'b01);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat;
        bit bok;
        int seen;

        rst        = 1'b1;
        req_valid  = 1'b1;
        resp_ready = 1'b1;
        ALU_sel    = 8'h01;
        operand1   = 8'd5;
        operand2   = 8'd6;
        repeat (3) @(negedge clk);
        check("reset req_ready", req_ready, 1);
        check("reset resp_valid", resp_valid, 0);
        check("reset result", operation_result, 0);
        check("reset flags", Flags, 0);
        rst       = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        check("post reset idle", {resp_valid, req_ready}, 2'b01);

        run_op("add",      8'h01, 8'd10,  8'd15,  8'd25,  7'h00, 1);
        run_op("add_wrap", 8'h01, 8'd255, 8'd1,   8'd0,   7'h13, 1);
        run_op("sub",      8'h02, 8'd1,   8'd2,   8'd255, 7'h15, 1);
        run_op("dec0",     8'h06, 8'd0,   8'd9,   8'd255, 7'h15, 1);
        run_op("inc_ovf",  8'h05, 8'h7F,  8'd0,   8'h80,  7'h0C, 1);
        run_op("shl",      8'h08, 8'h81,  8'd0,   8'h02,  7'h01, 1);
        run_op("shr",      8'h09, 8'h81,  8'd0,   8'h40,  7'h01, 1);
        run_op("nand",     8'h0B, 8'hF0,  8'h3C,  8'hCF,  7'h14, 1);

        run_op("mul",    8'h03, 8'd27, 8'd4,  MD ? 8'd108 : 8'd0, MD ? 7'h10 : 7'h52, MD ? 9 : 1);
        run_op("mul_hi", 8'h03, 8'd16, 8'd16, 8'd0,               MD ? 7'h13 : 7'h52, MD ? 9 : 1);
        run_op("div",    8'h04, 8'd16, 8'd4,  MD ? 8'd4 : 8'd0,   MD ? 7'h00 : 7'h52, MD ? 9 : 1);
        run_op("div0",   8'h04, 8'd8,  8'd0,  MD ? 8'd255 : 8'd0, MD ? 7'h34 : 7'h52, MD ? 9 : 1);
        run_op("mod",    8'h07, 8'd30, 8'd4,  MD ? 8'd2 : 8'd0,   MD ? 7'h00 : 7'h52, MD ? 9 : 1);
        run_op("mod0",   8'h07, 8'd9,  8'd0,  MD ? 8'd9 : 8'd0,   MD ? 7'h30 : 7'h52, MD ? 9 : 1);

        // Backpressure: response must hold while new requests and operands churn.
        resp_ready = 1'b0;
        issue("xor", 8'h11, 8'hAA, 8'hCC);
        wait_resp(lat, bok);
        check("xor latency", lat, 1);
        for (int i = 0; i < 5; i++) begin
            check("stall result", operation_result, 8'h66);
            check("stall flags", Flags, 7'h10);
            check("stall state", {resp_valid, req_ready}, 2'b10);
            req_valid = 1'b1;
            ALU_sel   = 8'($urandom_range(1, 17));
            operand1  = 8'($urandom);
            operand2  = 8'($urandom);
            @(negedge clk);
        end
        check("stall end result", operation_result, 8'h66);
        ALU_sel    = 8'h01;
        operand1   = 8'd1;
        operand2   = 8'd2;
        resp_ready = 1'b1;
        @(negedge clk);
        check("take no accept", {resp_valid, req_ready}, 2'b01);
        @(negedge clk);
        req_valid = 1'b0;
        check("b2b valid", resp_valid, 1);
        check("b2b result", operation_result, 8'd3);
        check("b2b flags", Flags, 7'h10);
        @(negedge clk);
        check("b2b taken", {resp_valid, req_ready}, 2'b01);

        // Reset in the middle of an operation abandons it.
        resp_ready = 1'b0;
        issue("rst_op", MD ? 8'h04 : 8'h01, 8'd100, 8'd7);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort result", operation_result, 0);
        check("abort flags", Flags, 0);
        check("abort state", {resp_valid, req_ready}, 2'b01);
        resp_ready = 1'b1;
        seen = 0;
        repeat (15) begin
            @(negedge clk);
            if (resp_valid !== 1'b0) seen++;
        end
        check("abort no response", seen, 0);

        run_op("invalid", 8'h0C, 8'd3, 8'd4, 8'd0, 7'h52, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
